// File: rtl/ram_bank_ctrl.sv
// Dual-read / single-write data-memory bank with a DEPTH-cycle zero-fill engine.
// Define RAM_BANK_RD_BYPASS_EN for write-first read/write collisions (read-first otherwise).
module ram_bank_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              rd_acc, wr_acc, clr_last;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    // Word returned for a read accepted this cycle; mem still holds pre-edge contents.
    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] ra);
`ifdef RAM_BANK_RD_BYPASS_EN
        if (wr_acc && (ra == wr_addr))
            return wr_data;
`endif
        return mem[ra];
    endfunction

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        rd_acc      = 1'b0;
        wr_acc      = 1'b0;
        clr_last    = 1'b0;
        case (state)
            IDLE: begin
                rd_acc = rd_req;
                wr_acc = wr_req & ~clr_req;
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (&clr_cnt) begin
                    clr_last  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A reset edge must not commit any write, so an aborted clear stops exactly where it was.
    assign ram_we    = rst_n & (wr_acc | (state == CLEAR));
    assign ram_waddr = (state == CLEAR) ? clr_cnt : wr_addr;
    assign ram_wdata = (state == CLEAR) ? '0 : wr_data;
    assign busy      = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
    end

    // Stage p0 -> p1: registered read data and completion pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
            wr_done   <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            rd_valid <= rd_acc;
            wr_done  <= wr_acc;
            clr_done <= clr_last;
            if (rd_acc) begin
                rd_data_a <= rd_word(rd_addr_a);
                rd_data_b <= rd_word(rd_addr_b);
            end
        end
    end

endmodule
